// File: rtl/crgu_pwr_seq.sv
// -----------------------------------------------------------------------------
// crgu_pwr_seq
//
// Always-on power/clock sequencer that sits directly upstream of crgu on the
// 32 kHz always-on clock.
// - Brings crgu up in a fixed order: clk_en, then shut_rstn, then data_ctrl_en.
// - Tears it down in reverse order on power-down or on a soft reset command.
// - A soft reset ends with an automatic power-up while rg_pwr_on stays high.
//
// Ports
//   clk_32k           in   always-on 32 kHz clock
//   rst_32k_alon      in   synchronous active-high reset
//   rg_pwr_on         in   level request: 1 = sequence up, 0 = sequence down
//   rg_top_start_req  in   top start request, honoured only in RUN
//   cmd_reset_pulse   in   one-cycle soft reset pulse (already on clk_32k)
//   clk_en            out  crgu clock enable
//   shut_rstn         out  crgu domain reset, active low
//   data_ctrl_en      out  crgu data control enable
//   rg_top_start      out  crgu top start
//   seq_busy          out  1 in any state other than OFF and RUN
//   seq_state         out  current state encoding
//   soft_rst_cnt      out  [7:0] saturating count of accepted soft resets
//                          (present only when CRGU_PWR_SEQ_RSTCNT_EN is defined)
//
// Optional feature macro: CRGU_PWR_SEQ_RSTCNT_EN
// -----------------------------------------------------------------------------
module crgu_pwr_seq #(
  parameter int CLK_SETTLE_CYC = 4,  // cycles in CLK_ON and RST_ASRT, 1..15
  parameter int RST_HOLD_CYC   = 2,  // cycles in RST_REL and STOP, 1..15
  parameter int CNT_W          = 4   // wait counter width
) (
  input  logic       clk_32k,
  input  logic       rst_32k_alon,
  input  logic       rg_pwr_on,
  input  logic       rg_top_start_req,
  input  logic       cmd_reset_pulse,
  output logic       clk_en,
  output logic       shut_rstn,
  output logic       data_ctrl_en,
  output logic       rg_top_start,
  output logic       seq_busy,
  output logic [2:0] seq_state
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
  ,
  output logic [7:0] soft_rst_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_CLK_ON   = 3'd1,
    ST_RST_REL  = 3'd2,
    ST_DATA_ON  = 3'd3,
    ST_RUN      = 3'd4,
    ST_STOP     = 3'd5,
    ST_RST_ASRT = 3'd6,
    ST_CLK_OFF  = 3'd7
  } state_t;

  // A timed state lasts N cycles: load N-1 on entry, leave when it reads 0.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(CLK_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             clk_en_reg, clk_en_next;
  logic             shut_rstn_reg, shut_rstn_next;
  logic             data_ctrl_en_reg, data_ctrl_en_next;
  logic             top_start_reg, top_start_next;
  logic             busy_reg, busy_next;
  logic             restart_pend_reg, restart_pend_next;
  logic             go_stop;

  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      state_reg        <= ST_OFF;
      cnt_reg          <= '0;
      clk_en_reg       <= 1'b0;
      shut_rstn_reg    <= 1'b0;
      data_ctrl_en_reg <= 1'b0;
      top_start_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      restart_pend_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      clk_en_reg       <= clk_en_next;
      shut_rstn_reg    <= shut_rstn_next;
      data_ctrl_en_reg <= data_ctrl_en_next;
      top_start_reg    <= top_start_next;
      busy_reg         <= busy_next;
      restart_pend_reg <= restart_pend_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    clk_en_next       = clk_en_reg;
    shut_rstn_next    = shut_rstn_reg;
    data_ctrl_en_next = data_ctrl_en_reg;
    top_start_next    = top_start_reg;
    restart_pend_next = restart_pend_reg;
    go_stop           = 1'b0;

    case (state_reg)
      ST_OFF: begin
        clk_en_next       = 1'b0;
        shut_rstn_next    = 1'b0;
        data_ctrl_en_next = 1'b0;
        top_start_next    = 1'b0;
        // restart_pend only marks a soft-reset restart; it still needs power.
        if (rg_pwr_on || (restart_pend_reg && rg_pwr_on)) begin
          state_next        = ST_CLK_ON;
          cnt_next          = SETTLE_LOAD;
          clk_en_next       = 1'b1;
          restart_pend_next = 1'b0;
        end
      end
      ST_CLK_ON: begin
        if (!rg_pwr_on) begin
          go_stop = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next     = ST_RST_REL;
          cnt_next       = HOLD_LOAD;
          shut_rstn_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RST_REL: begin
        if (!rg_pwr_on) begin
          go_stop = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next        = ST_DATA_ON;
          data_ctrl_en_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_DATA_ON: begin
        if (!rg_pwr_on) go_stop = 1'b1;
        else            state_next = ST_RUN;
      end
      ST_RUN: begin
        top_start_next = rg_top_start_req;
        if (cmd_reset_pulse) begin
          restart_pend_next = 1'b1;
          go_stop           = 1'b1;
        end else if (!rg_pwr_on) begin
          go_stop = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_reg == '0) begin
          state_next     = ST_RST_ASRT;
          cnt_next       = SETTLE_LOAD;
          shut_rstn_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RST_ASRT: begin
        if (cnt_reg == '0) begin
          state_next  = ST_CLK_OFF;
          clk_en_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_CLK_OFF: begin
        state_next = ST_OFF;
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase

    // Teardown entry, shared by power-down, soft reset and power-up abort.
    // shut_rstn is left as is so an abort from RST_REL/DATA_ON still holds
    // the domain for the full STOP time before reset is asserted.
    if (go_stop) begin
      state_next        = ST_STOP;
      cnt_next          = HOLD_LOAD;
      data_ctrl_en_next = 1'b0;
      top_start_next    = 1'b0;
    end

    busy_next = !((state_next == ST_OFF) || (state_next == ST_RUN));
  end

  assign clk_en       = clk_en_reg;
  assign shut_rstn    = shut_rstn_reg;
  assign data_ctrl_en = data_ctrl_en_reg;
  assign rg_top_start = top_start_reg;
  assign seq_busy     = busy_reg;
  assign seq_state    = state_reg;

`ifdef CRGU_PWR_SEQ_RSTCNT_EN
  logic [7:0] soft_rst_cnt_reg;

  // Counts every soft reset pulse accepted in RUN; sticks at 255.
  always_ff @(posedge clk_32k) begin
    if (rst_32k_alon) begin
      soft_rst_cnt_reg <= 8'd0;
    end else if ((state_reg == ST_RUN) && cmd_reset_pulse &&
                 (soft_rst_cnt_reg != 8'hFF)) begin
      soft_rst_cnt_reg <= soft_rst_cnt_reg + 8'd1;
    end
  end

  assign soft_rst_cnt = soft_rst_cnt_reg;
`endif

endmodule

// File: tb/tb_crgu_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_crgu_pwr_seq
//
// Directed bench for crgu_pwr_seq with default parameters. Expected output
// vectors {seq_state, seq_busy, clk_en, shut_rstn, data_ctrl_en, rg_top_start}
// are queued when a step is driven and compared after the following edge.
// Output invariants are checked after every edge.
// -----------------------------------------------------------------------------
module tb_crgu_pwr_seq;

  logic       clk_32k = 1'b0;
  logic       rst_32k_alon;
  logic       rg_pwr_on;
  logic       rg_top_start_req;
  logic       cmd_reset_pulse;
  logic       clk_en;
  logic       shut_rstn;
  logic       data_ctrl_en;
  logic       rg_top_start;
  logic       seq_busy;
  logic [2:0] seq_state;
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
  logic [7:0] soft_rst_cnt;
`endif

  always #5 clk_32k = ~clk_32k;

  crgu_pwr_seq dut (
    .clk_32k          (clk_32k),
    .rst_32k_alon     (rst_32k_alon),
    .rg_pwr_on        (rg_pwr_on),
    .rg_top_start_req (rg_top_start_req),
    .cmd_reset_pulse  (cmd_reset_pulse),
    .clk_en           (clk_en),
    .shut_rstn        (shut_rstn),
    .data_ctrl_en     (data_ctrl_en),
    .rg_top_start     (rg_top_start),
    .seq_busy         (seq_busy),
    .seq_state        (seq_state)
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
    ,
    .soft_rst_cnt     (soft_rst_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  // Expected vector; seq_busy is 1 outside OFF(0) and RUN(4).
  function automatic logic [7:0] mk(input logic [2:0] st, input logic ce,
                                    input logic sr, input logic dc,
                                    input logic ts);
    logic busy;
    busy = !((st == 3'd0) || (st == 3'd4));
    return {st, busy, ce, sr, dc, ts};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_32k);
    #1;
    n_assert++;
    assert (((!shut_rstn) || clk_en) && ((!data_ctrl_en) || shut_rstn) &&
            ((!rg_top_start) || (seq_state == 3'd4))) else begin
      n_fail++;
      $error("FAIL invariant: observed ce=%b sr=%b dc=%b ts=%b st=%0d expected ordered enables",
             clk_en, shut_rstn, data_ctrl_en, rg_top_start, seq_state);
    end
  endtask

  task automatic exp_tick(input string tag, input logic [7:0] e);
    string      t;
    logic [7:0] ev;
    logic [7:0] obs;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    tick();
    t   = tag_q.pop_front();
    ev  = exp_q.pop_front();
    obs = {seq_state, seq_busy, clk_en, shut_rstn, data_ctrl_en, rg_top_start};
    $display("txn %-12s obs=%h exp=%h", t, obs, ev);
    check8(t, obs, ev);
  endtask

  // rg_pwr_on already high from OFF: CLK_ON at e1, RST_REL e5, DATA_ON e7, RUN e8.
  task automatic power_up(input string pfx);
    for (int i = 1; i <= 4; i++) exp_tick($sformatf("%s_e%0d", pfx, i), mk(3'd1, 1, 0, 0, 0));
    for (int i = 5; i <= 6; i++) exp_tick($sformatf("%s_e%0d", pfx, i), mk(3'd2, 1, 1, 0, 0));
    exp_tick($sformatf("%s_e7", pfx), mk(3'd3, 1, 1, 1, 0));
    exp_tick($sformatf("%s_e8", pfx), mk(3'd4, 1, 1, 1, 0));
  endtask

  // Teardown from RUN: STOP e1, RST_ASRT e3, CLK_OFF e7, OFF e8.
  task automatic teardown(input string pfx);
    exp_tick($sformatf("%s_e1", pfx), mk(3'd5, 1, 1, 0, 0));
    cmd_reset_pulse = 1'b0;
    exp_tick($sformatf("%s_e2", pfx), mk(3'd5, 1, 1, 0, 0));
    for (int i = 3; i <= 6; i++) exp_tick($sformatf("%s_e%0d", pfx, i), mk(3'd6, 1, 0, 0, 0));
    exp_tick($sformatf("%s_e7", pfx), mk(3'd7, 0, 0, 0, 0));
    exp_tick($sformatf("%s_e8", pfx), mk(3'd0, 0, 0, 0, 0));
  endtask

  initial begin
    rst_32k_alon     = 1'b1;
    rg_pwr_on        = 1'b0;
    rg_top_start_req = 1'b0;
    cmd_reset_pulse  = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) exp_tick("reset", mk(3'd0, 0, 0, 0, 0));
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
    check8("cnt_reset", soft_rst_cnt, 8'd0);
`endif
    rst_32k_alon = 1'b0;
    exp_tick("idle", mk(3'd0, 0, 0, 0, 0));

    // Power-up
    rg_pwr_on = 1'b1;
    power_up("pu");

    // Top start follows the request one cycle later in RUN
    rg_top_start_req = 1'b1;
    exp_tick("ts_on", mk(3'd4, 1, 1, 1, 1));
    exp_tick("ts_hold", mk(3'd4, 1, 1, 1, 1));
    rg_top_start_req = 1'b0;
    exp_tick("ts_off", mk(3'd4, 1, 1, 1, 0));

    // Soft reset with request held high: rg_top_start stays 0 outside RUN
    rg_top_start_req = 1'b1;
    exp_tick("ts_on2", mk(3'd4, 1, 1, 1, 1));
    cmd_reset_pulse = 1'b1;
    teardown("sr_dn");
    power_up("sr_up");
    exp_tick("ts_after", mk(3'd4, 1, 1, 1, 1));
    rg_top_start_req = 1'b0;
    exp_tick("ts_off2", mk(3'd4, 1, 1, 1, 0));
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
    check8("cnt_one", soft_rst_cnt, 8'd1);

    // 300 further pulses, each followed by the 16-cycle restart back to RUN
    for (int i = 0; i < 300; i++) begin
      cmd_reset_pulse = 1'b1;
      tick();
      cmd_reset_pulse = 1'b0;
      repeat (15) tick();
      if (i == 252) check8("cnt_254", soft_rst_cnt, 8'd254);
    end
    check8("cnt_sat", soft_rst_cnt, 8'd255);
    exp_tick("sat_run", mk(3'd4, 1, 1, 1, 0));
`endif

    // Power-down from RUN with top start active
    rg_top_start_req = 1'b1;
    exp_tick("ts_on3", mk(3'd4, 1, 1, 1, 1));
    rg_pwr_on = 1'b0;
    teardown("pd");
    exp_tick("off_hold", mk(3'd0, 0, 0, 0, 0));
    rg_top_start_req = 1'b0;

    // Abort two cycles into CLK_ON
    rg_pwr_on = 1'b1;
    exp_tick("ab_e1", mk(3'd1, 1, 0, 0, 0));
    exp_tick("ab_e2", mk(3'd1, 1, 0, 0, 0));
    rg_pwr_on = 1'b0;
    exp_tick("ab_e3", mk(3'd5, 1, 0, 0, 0));
    exp_tick("ab_e4", mk(3'd5, 1, 0, 0, 0));
    for (int i = 5; i <= 8; i++) exp_tick($sformatf("ab_e%0d", i), mk(3'd6, 1, 0, 0, 0));
    exp_tick("ab_e9", mk(3'd7, 0, 0, 0, 0));
    exp_tick("ab_e10", mk(3'd0, 0, 0, 0, 0));

    // Reset asserted in RST_REL
    rg_pwr_on = 1'b1;
    for (int i = 1; i <= 4; i++) exp_tick($sformatf("mr_e%0d", i), mk(3'd1, 1, 0, 0, 0));
    exp_tick("mr_e5", mk(3'd2, 1, 1, 0, 0));
    rst_32k_alon = 1'b1;
    exp_tick("mid_rst", mk(3'd0, 0, 0, 0, 0));
`ifdef CRGU_PWR_SEQ_RSTCNT_EN
    check8("cnt_clr", soft_rst_cnt, 8'd0);
`endif
    rst_32k_alon = 1'b0;
    rg_pwr_on    = 1'b0;
    exp_tick("after_rst", mk(3'd0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
